// File: rtl/tl_ul_pkg.sv
// Shared TL-UL opcode encodings and the default-width D-channel response record.
package tl_ul_pkg;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  localparam int unsigned TL_SIZEBITS   = 4;
  localparam int unsigned TL_SOURCEBITS = 3;
  localparam int unsigned TL_ADDRLOBITS = 4;
  localparam int unsigned TL_DATABITS   = 32;

  // Layout at default widths; parametrised instances build the same field order locally.
  typedef struct packed {
    logic [2:0]               opcode;
    logic [TL_SIZEBITS-1:0]   size;
    logic [TL_SOURCEBITS-1:0] source;
    logic [TL_ADDRLOBITS-1:0] addr_lo;
    logic [TL_DATABITS-1:0]   data;
    logic                     error;
  } tl_d_rsp_t;

endpackage

// File: rtl/tl_rsp_fifo.sv
// Response queue for the D channel: DEPTH entries of WIDTH bits, head visible on pop_data.
module tl_rsp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/tl_ul_reg_slave.sv
// TL-UL register-file slave: single-beat Get/PutFull/PutPartial with a queued D channel.
// Optional error counter output enabled by defining TL_REG_SLAVE_ERRCNT_EN.
module tl_ul_reg_slave
  import tl_ul_pkg::*;
#(
  parameter int unsigned NREGS       = 4,
  parameter int unsigned SIZEBITS    = 4,
  parameter int unsigned SOURCEBITS  = 3,
  parameter int unsigned ADDRESSBITS = 12,
  parameter int unsigned DATABITS    = 32,
  parameter int unsigned SINKBITS    = 1,
  parameter int unsigned ADDRLOBITS  = 4,
  parameter int unsigned RSP_DEPTH   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   io_slave_a_ready,
  input  logic                   io_slave_a_valid,
  input  logic [2:0]             io_slave_a_bits_opcode,
  input  logic [2:0]             io_slave_a_bits_param,
  input  logic [SIZEBITS-1:0]    io_slave_a_bits_size,
  input  logic [SOURCEBITS-1:0]  io_slave_a_bits_source,
  input  logic [ADDRESSBITS-1:0] io_slave_a_bits_address,
  input  logic [DATABITS/8-1:0]  io_slave_a_bits_mask,
  input  logic [DATABITS-1:0]    io_slave_a_bits_data,
  input  logic                   io_slave_d_ready,
  output logic                   io_slave_d_valid,
  output logic [2:0]             io_slave_d_bits_opcode,
  output logic [1:0]             io_slave_d_bits_param,
  output logic [SIZEBITS-1:0]    io_slave_d_bits_size,
  output logic [SOURCEBITS-1:0]  io_slave_d_bits_source,
  output logic [SINKBITS-1:0]    io_slave_d_bits_sink,
  output logic [ADDRLOBITS-1:0]  io_slave_d_bits_addr_lo,
  output logic [DATABITS-1:0]    io_slave_d_bits_data,
  output logic                   io_slave_d_bits_error
`ifdef TL_REG_SLAVE_ERRCNT_EN
  ,
  output logic [15:0]            err_count
`endif
);

  localparam int unsigned MASKBITS = DATABITS / 8;
  localparam int unsigned OFFB     = $clog2(MASKBITS);
  localparam int unsigned IDXB     = $clog2(NREGS);

  typedef struct packed {
    logic [2:0]            opcode;
    logic [SIZEBITS-1:0]   size;
    logic [SOURCEBITS-1:0] source;
    logic [ADDRLOBITS-1:0] addr_lo;
    logic [DATABITS-1:0]   data;
    logic                  error;
  } rsp_t;

  logic [DATABITS-1:0] regs [NREGS];
  logic [IDXB-1:0]     idx;
  logic                a_fire;
  logic                is_put;
  logic                is_get;
  logic                hi_nz;
  logic                size_bad;
  logic                err;
  logic                fifo_full;
  logic                fifo_empty;
  logic                d_pop;
  rsp_t                rsp_in;
  rsp_t                rsp_out;
  logic                unused_param;

  assign unused_param = ^io_slave_a_bits_param;

  // Acceptance depends on queue occupancy only, so a full queue never accepts even while popping.
  assign io_slave_a_ready = !fifo_full;
  assign a_fire           = io_slave_a_valid && io_slave_a_ready;

  assign idx      = io_slave_a_bits_address[OFFB +: IDXB];
  assign hi_nz    = |(io_slave_a_bits_address >> (OFFB + IDXB));
  assign size_bad = io_slave_a_bits_size > SIZEBITS'(OFFB);
  assign is_put   = (io_slave_a_bits_opcode == PUT_FULL) || (io_slave_a_bits_opcode == PUT_PARTIAL);
  assign is_get   = (io_slave_a_bits_opcode == GET);
  assign err      = !(is_put || is_get) || hi_nz || size_bad;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (a_fire && is_put && !err) begin
      for (int unsigned b = 0; b < MASKBITS; b++) begin
        if (io_slave_a_bits_mask[b]) regs[idx][8*b +: 8] <= io_slave_a_bits_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    rsp_in         = '0;
    rsp_in.opcode  = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
    rsp_in.size    = io_slave_a_bits_size;
    rsp_in.source  = io_slave_a_bits_source;
    rsp_in.addr_lo = io_slave_a_bits_address[ADDRLOBITS-1:0];
    rsp_in.data    = (is_get && !err) ? regs[idx] : '0;
    rsp_in.error   = err;
  end

  assign d_pop = io_slave_d_valid && io_slave_d_ready;

  tl_rsp_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (a_fire),
    .push_data (rsp_in),
    .pop       (d_pop),
    .pop_data  (rsp_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign io_slave_d_valid        = !fifo_empty;
  assign io_slave_d_bits_opcode  = rsp_out.opcode;
  assign io_slave_d_bits_param   = '0;
  assign io_slave_d_bits_size    = rsp_out.size;
  assign io_slave_d_bits_source  = rsp_out.source;
  assign io_slave_d_bits_sink    = '0;
  assign io_slave_d_bits_addr_lo = rsp_out.addr_lo;
  assign io_slave_d_bits_data    = rsp_out.data;
  assign io_slave_d_bits_error   = rsp_out.error;

`ifdef TL_REG_SLAVE_ERRCNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (a_fire && err && (err_count != '1)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tl_ul_reg_slave.sv
// Scoreboard bench for tl_ul_reg_slave: directed A-channel requests, D responses checked in order.
module tb_tl_ul_reg_slave;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        a_ready;
  logic        a_valid = 1'b0;
  logic [2:0]  a_opcode = '0;
  logic [2:0]  a_param = '0;
  logic [3:0]  a_size = '0;
  logic [2:0]  a_source = '0;
  logic [11:0] a_address = '0;
  logic [3:0]  a_mask = '0;
  logic [31:0] a_data = '0;
  logic        d_ready = 1'b1;
  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic [2:0]  d_source;
  logic [0:0]  d_sink;
  logic [3:0]  d_addr_lo;
  logic [31:0] d_data;
  logic        d_error;
`ifdef TL_REG_SLAVE_ERRCNT_EN
  logic [15:0] err_count;
`endif

  tl_ul_reg_slave dut (
    .clock                   (clock),
    .reset                   (reset),
    .io_slave_a_ready        (a_ready),
    .io_slave_a_valid        (a_valid),
    .io_slave_a_bits_opcode  (a_opcode),
    .io_slave_a_bits_param   (a_param),
    .io_slave_a_bits_size    (a_size),
    .io_slave_a_bits_source  (a_source),
    .io_slave_a_bits_address (a_address),
    .io_slave_a_bits_mask    (a_mask),
    .io_slave_a_bits_data    (a_data),
    .io_slave_d_ready        (d_ready),
    .io_slave_d_valid        (d_valid),
    .io_slave_d_bits_opcode  (d_opcode),
    .io_slave_d_bits_param   (d_param),
    .io_slave_d_bits_size    (d_size),
    .io_slave_d_bits_source  (d_source),
    .io_slave_d_bits_sink    (d_sink),
    .io_slave_d_bits_addr_lo (d_addr_lo),
    .io_slave_d_bits_data    (d_data),
    .io_slave_d_bits_error   (d_error)
`ifdef TL_REG_SLAVE_ERRCNT_EN
    ,
    .err_count               (err_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  param;
    logic [3:0]  size;
    logic [2:0]  src;
    logic [0:0]  sink;
    logic [3:0]  alo;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;

  always @(posedge clock) cycle <= cycle + 1;

  function automatic exp_t mk(input logic [2:0] op, input logic [3:0] size, input logic [2:0] src,
                              input logic [3:0] alo, input logic [31:0] data, input logic err);
    exp_t e;
    e = '{op: op, param: 2'b00, size: size, src: src, sink: 1'b0, alo: alo, data: data, err: err};
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every D handshake is compared against the head of the scoreboard queue.
  initial begin
    exp_t got;
    exp_t e;
    forever begin
      @(negedge clock);
      if (d_valid && d_ready) begin
        got = '{op: d_opcode, param: d_param, size: d_size, src: d_source, sink: d_sink,
                alo: d_addr_lo, data: d_data, err: d_error};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL d_unexpected: got src=%0d data=%h with nothing expected", got.src, got.data);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL d_rsp: got op=%0d sz=%0d src=%0d alo=%h data=%h err=%b expected op=%0d sz=%0d src=%0d alo=%h data=%h err=%b",
                     got.op, got.size, got.src, got.alo, got.data, got.err,
                     e.op, e.size, e.src, e.alo, e.data, e.err);
          end
        end
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [11:0] addr, input logic [3:0] size,
                       input logic [3:0] mask, input logic [31:0] data, input logic [2:0] src);
    a_opcode  = op;
    a_address = addr;
    a_size    = size;
    a_mask    = mask;
    a_data    = data;
    a_source  = src;
    a_param   = 3'd5;
    a_valid   = 1'b1;
  endtask

  task automatic wait_accept(input exp_t e, output int acc_cycle);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (a_ready) begin
        @(posedge clock);
        #1;
        ok = 1'b1;
      end
    end
    acc_cycle = cycle;
    if (ok) exp_q.push_back(e);
    else begin
      total++;
      bad++;
      $display("FAIL a_accept: got no acceptance in 50 cycles expected acceptance");
    end
    a_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [11:0] addr, input logic [3:0] size,
                      input logic [3:0] mask, input logic [31:0] data, input logic [2:0] src,
                      input exp_t e);
    int c;
    drive(op, addr, size, mask, data, src);
    wait_accept(e, c);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clock);
    #1;
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int c_put;
    int c_get;
    int c_tmp;

    // Reset state
    #12;
    check("rst_d_valid", 32'(d_valid), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst_a_ready", 32'(a_ready), 32'd1);
    check("rst_d_valid_rel", 32'(d_valid), 32'd0);
`ifdef TL_REG_SLAVE_ERRCNT_EN
    check("rst_err_count", 32'(err_count), 32'd0);
`endif

    // 1: PutFull then Get
    send(3'd0, 12'h004, 4'd2, 4'hF, 32'hDEADBEEF, 3'd1, mk(3'd0, 4'd2, 3'd1, 4'h4, 32'h0, 1'b0));
    send(3'd4, 12'h004, 4'd2, 4'h0, 32'h0, 3'd2, mk(3'd1, 4'd2, 3'd2, 4'h4, 32'hDEADBEEF, 1'b0));

    // 2: PutPartial bytes 0 and 2
    send(3'd1, 12'h008, 4'd2, 4'h5, 32'h11223344, 3'd3, mk(3'd0, 4'd2, 3'd3, 4'h8, 32'h0, 1'b0));
    send(3'd4, 12'h008, 4'd2, 4'hF, 32'hFFFFFFFF, 3'd4, mk(3'd1, 4'd2, 3'd4, 4'h8, 32'h00220044, 1'b0));

    // 3: decode errors
    send(3'd4, 12'h100, 4'd2, 4'hF, 32'h0, 3'd5, mk(3'd1, 4'd2, 3'd5, 4'h0, 32'h0, 1'b1));
    send(3'd2, 12'h000, 4'd2, 4'hF, 32'hFFFFFFFF, 3'd6, mk(3'd0, 4'd2, 3'd6, 4'h0, 32'h0, 1'b1));
`ifdef TL_REG_SLAVE_ERRCNT_EN
    check("err_count_2", 32'(err_count), 32'd2);
`endif
    send(3'd4, 12'h000, 4'd3, 4'hF, 32'h0, 3'd7, mk(3'd1, 4'd3, 3'd7, 4'h0, 32'h0, 1'b1));
`ifdef TL_REG_SLAVE_ERRCNT_EN
    check("err_count_3", 32'(err_count), 32'd3);
`endif
    send(3'd4, 12'h000, 4'd2, 4'hF, 32'h0, 3'd0, mk(3'd1, 4'd2, 3'd0, 4'h0, 32'h0, 1'b0));
    send(3'd4, 12'h005, 4'd0, 4'h2, 32'h0, 3'd1, mk(3'd1, 4'd0, 3'd1, 4'h5, 32'hDEADBEEF, 1'b0));
    drain();

    // 4: backpressure fills the queue; third Get waits until a pop frees an entry
    d_ready = 1'b0;
    send(3'd4, 12'h000, 4'd2, 4'hF, 32'h0, 3'd1, mk(3'd1, 4'd2, 3'd1, 4'h0, 32'h0, 1'b0));
    send(3'd4, 12'h004, 4'd2, 4'hF, 32'h0, 3'd2, mk(3'd1, 4'd2, 3'd2, 4'h4, 32'hDEADBEEF, 1'b0));
    drive(3'd4, 12'h008, 4'd2, 4'hF, 32'h0, 3'd3);
    @(negedge clock);
    check("full_a_ready", 32'(a_ready), 32'd0);
    check("full_d_valid", 32'(d_valid), 32'd1);
    @(posedge clock); #1;
    d_ready = 1'b1;
    @(negedge clock);
    check("full_pop_a_ready", 32'(a_ready), 32'd0);
    wait_accept(mk(3'd1, 4'd2, 3'd3, 4'h8, 32'h00220044, 1'b0), c_tmp);
    drain();

    // 5: back-to-back Put/Get, one accept per cycle, response one cycle after acceptance
    check("idle_d_valid", 32'(d_valid), 32'd0);
    drive(3'd0, 12'h00C, 4'd2, 4'hF, 32'hCAFEF00D, 3'd4);
    wait_accept(mk(3'd0, 4'd2, 3'd4, 4'hC, 32'h0, 1'b0), c_put);
    check("latency1_d_valid", 32'(d_valid), 32'd1);
    drive(3'd4, 12'h00C, 4'd2, 4'hF, 32'h0, 3'd5);
    wait_accept(mk(3'd1, 4'd2, 3'd5, 4'hC, 32'hCAFEF00D, 1'b0), c_get);
    check("b2b_cycles", 32'(c_get - c_put), 32'd1);
    drain();

    // 6: reset with responses queued
    d_ready = 1'b0;
    send(3'd0, 12'h000, 4'd2, 4'hF, 32'h12345678, 3'd6, mk(3'd0, 4'd2, 3'd6, 4'h0, 32'h0, 1'b0));
    send(3'd0, 12'h004, 4'd2, 4'hF, 32'h9ABCDEF0, 3'd7, mk(3'd0, 4'd2, 3'd7, 4'h4, 32'h0, 1'b0));
    check("pre_rst_a_ready", 32'(a_ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_d_valid", 32'(d_valid), 32'd0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    d_ready = 1'b1;
    check("post_rst_a_ready", 32'(a_ready), 32'd1);
    send(3'd4, 12'h000, 4'd2, 4'hF, 32'h0, 3'd0, mk(3'd1, 4'd2, 3'd0, 4'h0, 32'h0, 1'b0));
    send(3'd4, 12'h004, 4'd2, 4'hF, 32'h0, 3'd1, mk(3'd1, 4'd2, 3'd1, 4'h4, 32'h0, 1'b0));
    send(3'd4, 12'h008, 4'd2, 4'hF, 32'h0, 3'd2, mk(3'd1, 4'd2, 3'd2, 4'h8, 32'h0, 1'b0));
    send(3'd4, 12'h00C, 4'd2, 4'hF, 32'h0, 3'd3, mk(3'd1, 4'd2, 3'd3, 4'hC, 32'h0, 1'b0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
